// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Tags are kept at their widest possible width so one entry type serves every table size.
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t CNT_SNT = 2'd0;
    localparam bp_cnt_t CNT_WNT = 2'd1;
    localparam bp_cnt_t CNT_WT  = 2'd2;
    localparam bp_cnt_t CNT_ST  = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        bp_cnt_t     cnt;
    } btb_entry_t;

    // Tag is the word address with the index bits shifted out (zero-extended).
    function automatic logic [29:0] pc_tag(input logic [29:0] word_addr, input int idx_w);
        return word_addr >> idx_w;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating up/down counter step used for every BTB entry update.
module bp_sat_cnt
    import bp_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       up,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (up) begin
            if (cnt_in != CNT_ST) begin
                cnt_out = cnt_in + 2'd1;
            end
        end else if (cnt_in != CNT_SNT) begin
            cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup on the fetch PC,
// updated from EX resolution, with at most one predicted-taken branch in flight.
module branch_pred_unit
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = CNT_WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    output logic        o_pred_jump,
    output logic [31:0] o_pred_pc,
    output logic        o_nt_pt,
    output logic        o_t_pnt,
    output logic        o_pending,
    output logic [15:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t       btb_q [ENTRIES];
    btb_entry_t       f_ent;
    btb_entry_t       e_ent;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic [29:0]      f_tag;
    logic [29:0]      e_tag;
    logic             f_hit;
    logic             e_hit;
    logic             e_tgt_ok;
    logic             pending_reg;
    logic [15:0]      mispred_cnt_reg;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{i_fetch_pc[1:0], i_ex_pc[1:0]};

    assign f_idx = i_fetch_pc[IDX_W+1:2];
    assign e_idx = i_ex_pc[IDX_W+1:2];
    assign f_tag = pc_tag(i_fetch_pc[31:2], IDX_W);
    assign e_tag = pc_tag(i_ex_pc[31:2], IDX_W);

    // Both lookups read the registered table, so a same-cycle update is not visible yet.
    assign f_ent    = btb_q[f_idx];
    assign e_ent    = btb_q[e_idx];
    assign f_hit    = f_ent.valid && (f_ent.tag == f_tag);
    assign e_hit    = e_ent.valid && (e_ent.tag == e_tag);
    assign e_tgt_ok = e_hit && (e_ent.target == i_ex_target);

    // A taken branch missing the BTB has no stored target, so it counts as a wrong target.
    assign o_nt_pt = !rst && i_ex_valid && i_ex_pred_taken && !i_ex_taken;
    assign o_t_pnt = !rst && i_ex_valid && i_ex_taken && (!i_ex_pred_taken || !e_tgt_ok);

    assign o_pred_jump = !rst && f_hit && f_ent.cnt[1] && !pending_reg && !i_hold
                         && !i_flush && !o_nt_pt && !o_t_pnt;
    assign o_pred_pc   = o_pred_jump ? f_ent.target : 32'd0;
    assign o_pending   = pending_reg;
    assign o_mispred_cnt = mispred_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else if (i_flush || (i_ex_valid && i_ex_pred_taken)) begin
            pending_reg <= 1'b0;
        end else if (o_pred_jump) begin
            pending_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_cnt_reg <= 16'd0;
        end else if ((o_nt_pt || o_t_pnt) && (mispred_cnt_reg != 16'hFFFF)) begin
            mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
        end
    end

    // Each entry owns its register and counter step; only the entry at e_idx may write.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        btb_entry_t entry_reg;
        logic [1:0] cnt_upd;
        logic       wr_en;

        bp_sat_cnt u_sat (
            .cnt_in  (entry_reg.cnt),
            .up      (i_ex_taken),
            .cnt_out (cnt_upd)
        );

        assign wr_en = i_ex_valid && (e_idx == IDX_W'(gi)) && (e_hit || i_ex_taken);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '{valid: 1'b0, tag: 30'd0, target: 32'd0, cnt: CNT_INIT};
            end else if (wr_en) begin
                if (e_hit) begin
                    entry_reg.cnt <= cnt_upd;
                    if (i_ex_taken) begin
                        entry_reg.target <= i_ex_target;
                    end
                end else begin
                    entry_reg <= '{valid: 1'b1, tag: e_tag, target: i_ex_target, cnt: CNT_WT};
                end
            end
        end

        assign btb_q[gi] = entry_reg;
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed-vector bench: the driver pushes each cycle's expected outputs into a queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_hold = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_fetch_pc = 32'd0;
    logic        i_ex_valid = 1'b0;
    logic [31:0] i_ex_pc = 32'd0;
    logic        i_ex_taken = 1'b0;
    logic [31:0] i_ex_target = 32'd0;
    logic        i_ex_pred_taken = 1'b0;
    logic        o_pred_jump;
    logic [31:0] o_pred_pc;
    logic        o_nt_pt;
    logic        o_t_pnt;
    logic        o_pending;
    logic [15:0] o_mispred_cnt;

    typedef struct {
        int          id;
        logic        pj;
        logic [31:0] ppc;
        logic        ntpt;
        logic        tpnt;
        logic        pend;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    branch_pred_unit #(.ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_hold          (i_hold),
        .i_flush         (i_flush),
        .i_fetch_pc      (i_fetch_pc),
        .i_ex_valid      (i_ex_valid),
        .i_ex_pc         (i_ex_pc),
        .i_ex_taken      (i_ex_taken),
        .i_ex_target     (i_ex_target),
        .i_ex_pred_taken (i_ex_pred_taken),
        .o_pred_jump     (o_pred_jump),
        .o_pred_pc       (o_pred_pc),
        .o_nt_pt         (o_nt_pt),
        .o_t_pnt         (o_t_pnt),
        .o_pending       (o_pending),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h, expected %h", id, fld, got, want);
        end
    endtask

    // Monitor: every driven cycle presents one response, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "pred_jump",   32'(o_pred_jump),   32'(e.pj));
            chk(e.id, "pred_pc",     o_pred_pc,          e.ppc);
            chk(e.id, "nt_pt",       32'(o_nt_pt),       32'(e.ntpt));
            chk(e.id, "t_pnt",       32'(o_t_pnt),       32'(e.tpnt));
            chk(e.id, "pending",     32'(o_pending),     32'(e.pend));
            chk(e.id, "mispred_cnt", 32'(o_mispred_cnt), 32'(e.cnt));
            $display("step %0d: pj=%0b ppc=%h ntpt=%0b tpnt=%0b pend=%0b cnt=%0d",
                     e.id, o_pred_jump, o_pred_pc, o_nt_pt, o_t_pnt, o_pending, o_mispred_cnt);
        end
    end

    task automatic cyc(input logic r, input logic hold, input logic flush, input logic [31:0] fpc,
                       input logic exv, input logic [31:0] expc, input logic ext,
                       input logic [31:0] extgt, input logic expt,
                       input logic pj, input logic [31:0] ppc, input logic ntpt,
                       input logic tpnt, input logic pend, input logic [15:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        i_hold          = hold;
        i_flush         = flush;
        i_fetch_pc      = fpc;
        i_ex_valid      = exv;
        i_ex_pc         = expc;
        i_ex_taken      = ext;
        i_ex_target     = extgt;
        i_ex_pred_taken = expt;
        step_id++;
        e.id = step_id; e.pj = pj; e.ppc = ppc; e.ntpt = ntpt;
        e.tpnt = tpnt; e.pend = pend; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        // In reset: outputs forced low even with a would-be nt_pt on the EX inputs
        cyc(1,0,0,'h40,  1,'h40,0,0,1,        0,0,0,0,0,0);
        cyc(0,0,0,'h40,  0,0,0,0,0,           0,0,0,0,0,0);
        // Allocate 0x40 -> 0x100 and 0x84 -> 0x300, both unpredicted
        cyc(0,0,0,'h40,  1,'h40,1,'h100,0,    0,0,0,1,0,0);
        cyc(0,0,0,'h40,  1,'h84,1,'h300,0,    0,0,0,1,0,1);
        cyc(0,0,0,'h40,  0,0,0,0,0,           1,'h100,0,0,0,2);
        // Pending blocks the second hit; nt_pt resolution clears it
        cyc(0,0,0,'h84,  0,0,0,0,0,           0,0,0,0,1,2);
        cyc(0,0,0,'h84,  1,'h40,0,0,1,        0,0,1,0,1,2);
        cyc(0,0,0,'h84,  0,0,0,0,0,           1,'h300,0,0,0,3);
        cyc(0,0,0,'h0,   1,'h84,1,'h300,1,    0,0,0,0,1,3);
        // Hold for three cycles, then exactly one prediction
        cyc(0,1,0,'h84,  0,0,0,0,0,           0,0,0,0,0,3);
        cyc(0,1,0,'h84,  0,0,0,0,0,           0,0,0,0,0,3);
        cyc(0,1,0,'h84,  0,0,0,0,0,           0,0,0,0,0,3);
        cyc(0,0,0,'h84,  0,0,0,0,0,           1,'h300,0,0,0,3);
        cyc(0,0,0,'h84,  0,0,0,0,0,           0,0,0,0,1,3);
        cyc(0,0,1,'h0,   0,0,0,0,0,           0,0,0,0,1,3);
        cyc(0,0,1,'h84,  0,0,0,0,0,           0,0,0,0,0,3);
        // Retrain 0x40 (cnt 1->2), then wrong-target resolution to 0x200
        cyc(0,0,0,'h0,   1,'h40,1,'h100,0,    0,0,0,1,0,3);
        cyc(0,0,0,'h40,  0,0,0,0,0,           1,'h100,0,0,0,4);
        cyc(0,0,0,'h0,   1,'h40,1,'h200,1,    0,0,0,1,1,4);
        cyc(0,0,0,'h40,  0,0,0,0,0,           1,'h200,0,0,0,5);
        cyc(0,0,1,'h0,   0,0,0,0,0,           0,0,0,0,1,5);
        // Same-index lookup and update: lookup still sees the strongly-taken entry
        cyc(0,0,0,'h40,  1,'h40,0,0,0,        1,'h200,0,0,0,5);
        cyc(0,0,1,'h0,   0,0,0,0,0,           0,0,0,0,1,5);
        // 0x440 aliases 0x40 and evicts it
        cyc(0,0,0,'h0,   1,'h440,1,'h500,0,   0,0,0,1,0,5);
        cyc(0,0,0,'h40,  0,0,0,0,0,           0,0,0,0,0,6);
        cyc(0,0,0,'h440, 0,0,0,0,0,           1,'h500,0,0,0,6);
        cyc(0,0,1,'h0,   0,0,0,0,0,           0,0,0,0,1,6);
        // Miss and not-taken must not allocate
        cyc(0,0,0,'h8,   1,'h8,0,0,0,         0,0,0,0,0,6);
        cyc(0,0,0,'h8,   0,0,0,0,0,           0,0,0,0,0,6);
        cyc(0,0,0,'h84,  0,0,0,0,0,           1,'h300,0,0,0,6);
        // Mid-operation reset clears pending, counter and table immediately
        cyc(1,0,0,'h84,  0,0,0,0,0,           0,0,0,0,0,0);
        cyc(0,0,0,'h84,  0,0,0,0,0,           0,0,0,0,0,0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
